bp_read_control: RTL

- DDR-to-buffer-pool loader; the read-direction counterpart of the buffer-pool-to-DDR write controller.
- On `conf`, issues one DDR read request to the AXI read engine and accepts the returned beats into an internal FIFO.
- Scatters the beats into the buffer-pool (BP) banks: two consecutive lines into two adjacent MAC columns, across all X_MESH rows.
- Sits between the AXI read user interface and the BP SRAM write ports.

---
 rtl/bp_ctrl_pkg.sv | 24 ++
 rtl/bp_sync_fifo.sv | 67 ++++++
 rtl/bp_read_control.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bp_ctrl_pkg.sv
// Shared definitions for the buffer-pool DDR controllers.
// Holds the controller state encoding, the default beat-FIFO sizing and the
// bank-index mapping used by both the read and the write controller.
package bp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH_DEF = 16;
    localparam int FIFO_SLACK_DEF = 4;

    // Bank b serves MAC column n of mesh row m.
    function automatic int unsigned bank_idx(
        input int unsigned n,
        input int unsigned m,
        input int unsigned x_mac
    );
        return n + m * x_mac;
    endfunction

endpackage

// File: rtl/bp_sync_fifo.sv
// Synchronous single-clock FIFO for DDR read beats.
// Ports: clk/rst (sync, active high), push/din write side, pop/dout read side
// with one-cycle read latency (dout updates the cycle after an accepted pop),
// count/empty/full status. Pushes while full and pops while empty are ignored.
module bp_sync_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty     = (r_count == CW'(0));
    assign full      = (r_count == CW'(DEPTH));
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign count     = r_count;
    assign dout      = r_dout;

    // Storage array: written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, occupancy count and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bp_read_control.sv
// DDR-to-buffer-pool loader.
// On conf, issues one DDR read request (ddr_st_addr_out/ddr_len/ddr_conf),
// buffers returned beats (ddr_read_valid/ddr_read_data_in) in a FIFO with
// almost-full backpressure (ddr_read_full), and scatters 2*Line_width beats
// into the BP banks: line 0 into MAC column BP_st_num, line 1 into the next
// column, each line at addresses BP_st_addr.. across all mesh rows.
// Outputs BP_wr_en/BP_addr_out/BP_data_out are registered; overflow is a
// sticky dropped-beat flag; idle reports that nothing is in flight.
module bp_read_control
    import bp_ctrl_pkg::*;
#(
    parameter int X_MAC        = 4,
    parameter int X_MESH       = 16,
    parameter int DDR_ADDR_LEN = 32,
    parameter int ADDR_LEN     = 16,
    parameter int DATA_LEN     = 16,
    parameter int DDR_DATA_LEN = 256,
    parameter int SINGLE_LEN   = 24,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int FIFO_SLACK   = FIFO_SLACK_DEF,
    parameter int BUFFER_NUM   = X_MAC * X_MESH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           conf,
    input  logic [SINGLE_LEN-1:0]          data_ddr_byte,
    input  logic [DDR_ADDR_LEN-1:0]        ddr_st_addr,
    input  logic [ADDR_LEN-1:0]            BP_st_addr,
    input  logic [1:0]                     BP_st_num,
    input  logic [SINGLE_LEN-1:0]          Line_width,
    input  logic                           axi_ug_idle,
    output logic [DDR_ADDR_LEN-1:0]        ddr_st_addr_out,
    output logic [SINGLE_LEN-1:0]          ddr_len,
    output logic                           ddr_conf,
    input  logic                           ddr_read_valid,
    input  logic [DDR_DATA_LEN-1:0]        ddr_read_data_in,
    output logic                           ddr_read_full,
    output logic [BUFFER_NUM-1:0]          BP_wr_en,
    output logic [ADDR_LEN*BUFFER_NUM-1:0] BP_addr_out,
    output logic [DATA_LEN*BUFFER_NUM-1:0] BP_data_out,
    output logic                           overflow,
    output logic                           idle
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      w_accept;
    logic                      w_pop;
    logic                      w_last_in_line;
    logic [DDR_DATA_LEN-1:0]   w_fifo_dout;
    logic [CW-1:0]             w_fifo_count;
    logic                      w_fifo_empty;
    logic                      w_fifo_full;

    logic [ADDR_LEN-1:0]       r_bp_st_addr;
    logic [1:0]                r_bp_st_num;
    logic [SINGLE_LEN-1:0]     r_line_width;
    logic [DDR_ADDR_LEN-1:0]   r_ddr_st_addr_out;
    logic [SINGLE_LEN-1:0]     r_ddr_len;
    logic [SINGLE_LEN-1:0]     r_cnt_in_line;
    logic                      r_cnt_line;
    logic                      r_s1_vld;
    logic [1:0]                r_s1_col;
    logic [ADDR_LEN-1:0]       r_s1_addr;
    logic [BUFFER_NUM-1:0]          r_bp_wr_en;
    logic [ADDR_LEN*BUFFER_NUM-1:0] r_bp_addr;
    logic [DATA_LEN*BUFFER_NUM-1:0] r_bp_data;
    logic                      r_overflow;

    bp_sync_fifo #(
        .WIDTH (DDR_DATA_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ddr_read_valid),
        .din   (ddr_read_data_in),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

    assign w_last_in_line = (r_cnt_in_line == (r_line_width - SINGLE_LEN'(1)));

    // Next-state logic, job acceptance and FIFO pop control.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (conf && (Line_width != SINGLE_LEN'(0))) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_pop = !w_fifo_empty;
                // Only the pop that closes line 1 ends the job.
                if (w_pop && w_last_in_line && r_cnt_line) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Job parameter capture and DDR request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bp_st_addr      <= '0;
            r_bp_st_num       <= '0;
            r_line_width      <= '0;
            r_ddr_st_addr_out <= '0;
            r_ddr_len         <= '0;
        end else if (w_accept) begin
            r_bp_st_addr      <= BP_st_addr;
            r_bp_st_num       <= BP_st_num;
            r_line_width      <= Line_width;
            r_ddr_st_addr_out <= ddr_st_addr;
            r_ddr_len         <= data_ddr_byte;
        end
    end

    // Position counters: beat within line and line index, advanced per pop.
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_cnt_in_line <= '0;
            r_cnt_line    <= 1'b0;
        end else if (w_pop) begin
            if (w_last_in_line) begin
                r_cnt_in_line <= '0;
                r_cnt_line    <= ~r_cnt_line;
            end else begin
                r_cnt_in_line <= r_cnt_in_line + SINGLE_LEN'(1);
            end
        end
    end

    // Stage 1: column/address of the pop, aligned with the FIFO read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_col  <= '0;
            r_s1_addr <= '0;
        end else begin
            r_s1_vld <= w_pop;
            if (w_pop) begin
                r_s1_col  <= r_bp_st_num + {1'b0, r_cnt_line};
                r_s1_addr <= r_bp_st_addr + r_cnt_in_line[ADDR_LEN-1:0];
            end
        end
    end

    // Stage 2: registered bank strobes, addresses and per-row data slices.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bp_wr_en <= '0;
            r_bp_addr  <= '0;
            r_bp_data  <= '0;
        end else begin
            for (int unsigned m = 0; m < X_MESH; m++) begin
                for (int unsigned n = 0; n < X_MAC; n++) begin
                    r_bp_wr_en[bank_idx(n, m, X_MAC)] <= r_s1_vld && (n == 32'(r_s1_col));
                    if (r_s1_vld) begin
                        r_bp_addr[bank_idx(n, m, X_MAC)*ADDR_LEN +: ADDR_LEN] <= r_s1_addr;
                        r_bp_data[bank_idx(n, m, X_MAC)*DATA_LEN +: DATA_LEN] <=
                            w_fifo_dout[m*DATA_LEN +: DATA_LEN];
                    end
                end
            end
        end
    end

    // Sticky flag for a beat dropped because the FIFO had no room.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (ddr_read_valid && w_fifo_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign ddr_st_addr_out = r_ddr_st_addr_out;
    assign ddr_len         = r_ddr_len;
    assign ddr_conf        = (r_state == ST_REQ);
    assign ddr_read_full   = (w_fifo_count >= CW'(FIFO_DEPTH - FIFO_SLACK));
    assign BP_wr_en        = r_bp_wr_en;
    assign BP_addr_out     = r_bp_addr;
    assign BP_data_out     = r_bp_data;
    assign overflow        = r_overflow;
    assign idle            = (r_state == ST_IDLE) && !r_s1_vld && !(|r_bp_wr_en)
                             && w_fifo_empty && axi_ug_idle;

endmodule
